// File: rtl/adder_32_arbiter.sv
// -----------------------------------------------------------------------------
// adder_32_arbiter
//
// Purpose:
//   Shares one external 32-bit adder between two requesters. An operation is
//   accepted in IDLE, the winner's operands are latched onto the adder inputs,
//   the adder result is captured one cycle later (CALC), and the winner sees a
//   one-cycle done pulse (DONE). One operation completes every three cycles.
//
// Configuration macro:
//   ADDER_ARB_RR_EN  defined   -> round-robin tie-break, with a one-bit
//                                 "last served" pointer.
//                    undefined -> fixed priority, requester 0 wins ties and
//                                 no pointer register exists.
//
// Ports:
//   clk                 rising-edge clock for all state
//   rst_n               synchronous active-low reset
//   req0 / req1         requester N has valid operands (held until gntN)
//   a0, b0 / a1, b1     requester N operands, 32 bits
//   cin0 / cin1         requester N carry-in
//   gnt0 / gnt1         one-cycle pulse: requester N operands accepted
//   done0 / done1       one-cycle pulse: sum_out/cout_out valid for requester N
//   sum_out, cout_out   registered result and carry-out
//   add_a, add_b        operands driven to the shared adder
//   add_cin             carry-in driven to the shared adder
//   add_sum, add_cout   combinational result returned by the shared adder
// -----------------------------------------------------------------------------
module adder_32_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        cin0,
    input  logic        cin1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] sum_out,
    output logic        cout_out,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic        accept_s;     // an operation is accepted at this edge
    logic        win_s;        // winning requester index (0 or 1)
    logic        owner_r;      // requester that owns the operation in flight

    logic        gnt0_r;
    logic        gnt1_r;
    logic        done0_r;
    logic        done1_r;
    logic [31:0] sum_out_r;
    logic        cout_out_r;
    logic [31:0] add_a_r;
    logic [31:0] add_b_r;
    logic        add_cin_r;

`ifdef ADDER_ARB_RR_EN
    logic        last_r;       // requester served most recently
`endif

    // Arbitration: requests are only looked at while idle.
    always_comb begin
        accept_s = 1'b0;
        win_s    = 1'b0;
        if (state_r == ST_IDLE) begin
            if (req0 && req1) begin
                accept_s = 1'b1;
`ifdef ADDER_ARB_RR_EN
                // Tie goes to whoever was not served last.
                win_s    = ~last_r;
`else
                win_s    = 1'b0;
`endif
            end else if (req0) begin
                accept_s = 1'b1;
                win_s    = 1'b0;
            end else if (req1) begin
                accept_s = 1'b1;
                win_s    = 1'b1;
            end else begin
                accept_s = 1'b0;
                win_s    = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
            win_s    = 1'b0;
        end
    end

    // Next-state logic for IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant pulses: set at the accepting edge so they are high during CALC only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
        end else begin
            gnt0_r <= accept_s & ~win_s;
            gnt1_r <= accept_s &  win_s;
        end
    end

    // Done pulses: set at the closing edge of CALC so they are high during DONE only.
    // Reset clears them, which aborts an operation in flight without a done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done0_r <= 1'b0;
            done1_r <= 1'b0;
        end else begin
            done0_r <= (state_r == ST_CALC) & ~owner_r;
            done1_r <= (state_r == ST_CALC) &  owner_r;
        end
    end

    // Operand latch and owner record; the adder inputs only move on acceptance,
    // so requester operand changes after that edge cannot disturb the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_r   <= 1'b0;
            add_a_r   <= 32'd0;
            add_b_r   <= 32'd0;
            add_cin_r <= 1'b0;
        end else if (accept_s) begin
            owner_r   <= win_s;
            add_a_r   <= win_s ? a1   : a0;
            add_b_r   <= win_s ? b1   : b0;
            add_cin_r <= win_s ? cin1 : cin0;
        end else begin
            owner_r   <= owner_r;
            add_a_r   <= add_a_r;
            add_b_r   <= add_b_r;
            add_cin_r <= add_cin_r;
        end
    end

    // Result capture from the shared adder at the end of CALC; held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_out_r  <= 32'd0;
            cout_out_r <= 1'b0;
        end else if (state_r == ST_CALC) begin
            sum_out_r  <= add_sum;
            cout_out_r <= add_cout;
        end else begin
            sum_out_r  <= sum_out_r;
            cout_out_r <= cout_out_r;
        end
    end

`ifdef ADDER_ARB_RR_EN
    // Round-robin pointer; after reset requester 1 counts as last served so
    // requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (accept_s) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    assign gnt0     = gnt0_r;
    assign gnt1     = gnt1_r;
    assign done0    = done0_r;
    assign done1    = done1_r;
    assign sum_out  = sum_out_r;
    assign cout_out = cout_out_r;
    assign add_a    = add_a_r;
    assign add_b    = add_b_r;
    assign add_cin  = add_cin_r;

endmodule
